freqmeter_mc: RTL and testbench
===============================

Name: freqmeter_mc

Overview:
Multi-channel gated frequency meter, parametrised successor of the single-channel meter feeding the 7-segment display path. Counts rising edges on N_CH asynchronous inputs over a common gate of gate_ms ticks of the shared ce_1ms strobe. Gates run back-to-back with no dead time. Latched per-channel results are presented both as one muxed word for the display and as a flat bus; each result carries an overflow flag.

Parameters:
N_CH, 2, number of measured input channels (1..16)
CNT_W, 16, width of each edge counter and result word
GATE_W, 10, width of gate_ms (maximum gate 2^GATE_W-1 ms)
SEL_W, 1, width of ch_sel; must be at least clog2(N_CH), minimum 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
ce_1ms  in  1  one-clk strobe, one per millisecond
gate_ms  in  GATE_W  gate length in ce_1ms ticks; value 0 is treated as 1
sig_in  in  N_CH  asynchronous signals under measurement
hold  in  1  1 = freeze published results; counting continues
ch_sel  in  SEL_W  selects the channel shown on dat/ovf_sel
dat  out  CNT_W  result of the selected channel (combinational mux of result regs)
ovf_sel  out  1  overflow flag of the selected channel
dat_all  out  N_CH*CNT_W  all results; channel k occupies bits [k*CNT_W +: CNT_W]
ovf  out  N_CH  per-channel overflow flag of the last published gate
vld  out  1  one-clk pulse when new results are published
busy  out  1  1 while in GATE state

Behaviour:
- Reset (async, rst=1): all sync/edge flops, counters, result regs, ovf, vld, and ms_cnt cleared; state = ARM; busy=0.
- Input conditioning per channel: 2-FF synchroniser, then a third flop for rising-edge detect (edge = s2 & ~s3). Edge-detect latency from a sig_in rise is 3 clk. Input pulses must be at least 2 clk wide to be counted; shorter pulses are not guaranteed.
- FSM, two states:
  - ARM: counters held at 0. On ce_1ms: ms_cnt <= max(gate_ms,1); go to GATE.
  - GATE: on each ce_1ms with ms_cnt>1, ms_cnt decrements. On ce_1ms with ms_cnt==1 (terminal tick):
    - if hold=0, result[k] <= cnt[k] and ovf[k] <= ovf_acc[k];
    - cnt[k] <= edge[k] ? 1 : 0 and ovf_acc <= 0;
    - ms_cnt <= max(gate_ms,1), re-sampling gate_ms;
    - stay in GATE.
- Window rule: an edge detected on a terminal-tick cycle belongs to the new window. Each window spans exactly gate_ms*T_1ms clk cycles, with no lost edges between windows.
- vld: registered. It is 1 on the cycle after a terminal tick when hold=0, and 0 otherwise. Results and vld become visible together.
- Counter arithmetic: an edge increments cnt[k]. At all-ones, the FREQMETER_SATURATE_EN behaviour applies. ovf_acc[k] is set whenever an edge arrives while cnt[k] is all-ones.
- gate_ms changes mid-gate take effect only at the next gate start.
- ch_sel >= N_CH: dat = 0, ovf_sel = 0.
- hold=1 at a terminal tick: results, ovf, and vld are unchanged (vld stays 0). Counters still restart.
- rst mid-gate: partial counts are discarded and results are cleared. The FSM waits in ARM for the next ce_1ms.

Optional Feature:
FREQMETER_SATURATE_EN
- Defined: cnt[k] sticks at 2^CNT_W-1 once reached.
- Undefined: cnt[k] wraps to 0 (modulo 2^CNT_W).
- ovf_acc and ovf are set identically in both builds.

Test Plan:
1. Defaults; bench ce_1ms every 10 clk; gate_ms=10; sig_in[0] rising every 4 clk; sig_in[1]=0 -> from the 2nd vld on: result0=25, result1=0, ovf=00, and vld pulses exactly every 100 clk.
2. gate_ms=0, same stimulus -> gate = 1 tick = 10 clk; every vld after the first reports result0 with 2 or 3 edges, summing to 5 over any 2 consecutive gates.
3. CNT_W=4, 25 edges per gate:
   - with FREQMETER_SATURATE_EN: result0=15, ovf[0]=1;
   - without: result0=9, ovf[0]=1.
4. Raise hold for one terminal tick while the input rate changes from 25 to 50 edges/gate -> no vld at that tick and result0 stays 25. The next gate after hold drops gives result0=50.
5. Assert rst for 3 clk mid-gate -> all outputs 0 immediately (asynchronous). The first vld after release comes gate_ms ticks after the first ce_1ms post-reset, with a correct count.
6. ch_sel sweep 0, 1, then 2 with SEL_W=2 and N_CH=2 -> dat equals result0, then result1, then 0; dat_all always equals {result1, result0}.

Source files
------------

// File: rtl/freqmeter_mc_if.sv
// Bus bundle for the multi-channel gated frequency meter (freqmeter_mc).
// master drives measurement controls and inputs; slave is the meter itself.
interface freqmeter_mc_if #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 10,
  parameter int SEL_W  = 1
);
  logic                    ce_1ms;
  logic [GATE_W-1:0]       gate_ms;
  logic [N_CH-1:0]         sig_in;
  logic                    hold;
  logic [SEL_W-1:0]        ch_sel;
  logic [CNT_W-1:0]        dat;
  logic                    ovf_sel;
  logic [N_CH*CNT_W-1:0]   dat_all;
  logic [N_CH-1:0]         ovf;
  logic                    vld;
  logic                    busy;

  modport master (
    output ce_1ms, gate_ms, sig_in, hold, ch_sel,
    input  dat, ovf_sel, dat_all, ovf, vld, busy
  );
  modport slave (
    input  ce_1ms, gate_ms, sig_in, hold, ch_sel,
    output dat, ovf_sel, dat_all, ovf, vld, busy
  );
endinterface

// File: rtl/freqmeter_mc.sv
// Multi-channel gated frequency meter: back-to-back gates of gate_ms ce_1ms ticks.
// Build option FREQMETER_SATURATE_EN: counters stick at all-ones instead of wrapping.

module freqmeter_mc_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             clr,
  input  logic             start,
  input  logic             pub,
  output logic [CNT_W-1:0] res,
  output logic             ovf
);
  logic [2:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_q, res_d;
  logic             acc_q, acc_d, ovf_q, ovf_d;
  logic             edge_w;

  assign edge_w = sync_q[1] & ~sync_q[2];

  always_comb begin
    sync_d = {sync_q[1:0], sig};
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    if (pub) begin
      res_d = cnt_q;
      ovf_d = acc_q;
    end
    // An edge on the window boundary opens the new window's count.
    if (clr) begin
      cnt_d = '0;
      acc_d = 1'b0;
    end else if (start) begin
      cnt_d = CNT_W'(edge_w);
      acc_d = 1'b0;
    end else if (edge_w) begin
      if (&cnt_q) acc_d = 1'b1;
`ifdef FREQMETER_SATURATE_EN
      if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
`else
      cnt_d = cnt_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      acc_q  <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
    end
  end

  assign res = res_q;
  assign ovf = ovf_q;
endmodule

module freqmeter_mc #(
  parameter int N_CH   = 2,
  parameter int CNT_W  = 16,
  parameter int GATE_W = 10,
  parameter int SEL_W  = 1
) (
  input  logic           clk,
  input  logic           rst,
  freqmeter_mc_if.slave  bus
);
  typedef enum logic {ARM, GATE} state_t;

  state_t                      state_q, state_d;
  logic [GATE_W-1:0]           ms_q, ms_d, gate_len;
  logic                        vld_q, vld_d;
  logic                        clr, start, term, pub;
  logic [N_CH-1:0]             sig_w, ovf_w;
  logic [N_CH-1:0][CNT_W-1:0]  res;
  logic [CNT_W-1:0]            dat_w;
  logic                        ovf_sel_w;

  assign gate_len = (bus.gate_ms == '0) ? GATE_W'(1) : bus.gate_ms;

  always_comb begin
    state_d = state_q;
    ms_d    = ms_q;
    clr     = 1'b0;
    start   = 1'b0;
    term    = 1'b0;
    case (state_q)
      ARM: begin
        clr = ~bus.ce_1ms;
        if (bus.ce_1ms) begin
          start   = 1'b1;
          ms_d    = gate_len;
          state_d = GATE;
        end
      end
      default: begin
        if (bus.ce_1ms) begin
          if (ms_q == GATE_W'(1)) begin
            term  = 1'b1;
            start = 1'b1;
            ms_d  = gate_len;
          end else begin
            ms_d = ms_q - 1'b1;
          end
        end
      end
    endcase
    pub   = term & ~bus.hold;
    vld_d = pub;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARM;
      ms_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ms_q    <= ms_d;
      vld_q   <= vld_d;
    end
  end

  assign sig_w = bus.sig_in;

  freqmeter_mc_lane #(.CNT_W(CNT_W)) u_lane [N_CH-1:0] (
    .clk   (clk),
    .rst   (rst),
    .sig   (sig_w),
    .clr   (clr),
    .start (start),
    .pub   (pub),
    .res   (res),
    .ovf   (ovf_w)
  );

  // Out-of-range selects fall through to zero.
  always_comb begin
    dat_w     = '0;
    ovf_sel_w = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.ch_sel == SEL_W'(k)) begin
        dat_w     = res[k];
        ovf_sel_w = ovf_w[k];
      end
    end
  end

  assign bus.dat     = dat_w;
  assign bus.ovf_sel = ovf_sel_w;
  assign bus.dat_all = res;
  assign bus.ovf     = ovf_w;
  assign bus.vld     = vld_q;
  assign bus.busy    = (state_q == GATE);
endmodule

// File: tb/tb_freqmeter_mc.sv
// Directed bench for freqmeter_mc: a wide-counter DUT (a) and a 4-bit-counter DUT (b)
// share one stimulus stream; ce_1ms every 10 clk.
module tb_freqmeter_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef FREQMETER_SATURATE_EN
  localparam int EXP_B = 15;
`else
  localparam int EXP_B = 9;
`endif

  freqmeter_mc_if #(.N_CH(2), .CNT_W(16), .GATE_W(10), .SEL_W(2)) ifa ();
  freqmeter_mc_if #(.N_CH(2), .CNT_W(4),  .GATE_W(10), .SEL_W(1)) ifb ();

  freqmeter_mc #(.N_CH(2), .CNT_W(16), .GATE_W(10), .SEL_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  freqmeter_mc #(.N_CH(2), .CNT_W(4), .GATE_W(10), .SEL_W(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  assign ifb.ce_1ms  = ifa.ce_1ms;
  assign ifb.gate_ms = ifa.gate_ms;
  assign ifb.sig_in  = ifa.sig_in;
  assign ifb.hold    = ifa.hold;
  assign ifb.ch_sel  = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int per0  = 4;
  bit en0   = 1'b0;
  bit en1   = 1'b0;
  int cyc_n = 0;

  // Free-running stimulus: ce strobe and clock-synchronous square waves.
  initial begin
    ifa.ce_1ms = 1'b0;
    ifa.sig_in = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      ifa.ce_1ms    = (cyc_n % 10 == 0);
      ifa.sig_in[0] = en0 && ((cyc_n % per0) < (per0 / 2));
      ifa.sig_in[1] = en1 && ((cyc_n % 5) < 2);
    end
  end

  task automatic wait_vld(output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      waited++;
      if (ifa.vld) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL vld_timeout: no vld within %0d clk", waited);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ifa.dat_all !== 32'd0) begin n_err++; $display("FAIL rst_dat_all: got %0h exp 0", ifa.dat_all); end
    n_cmp++; if (ifa.vld !== 1'b0) begin n_err++; $display("FAIL rst_vld: got %0b exp 0", ifa.vld); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b exp 0", ifa.busy); end
    n_cmp++; if (ifa.ovf !== 2'b00) begin n_err++; $display("FAIL rst_ovf: got %0b exp 0", ifa.ovf); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    bit ok; int w;
    en0 = 1'b1; per0 = 4;
    wait_vld(ok, w);
    wait_vld(ok, w);
    n_cmp++; if (w !== 100) begin n_err++; $display("FAIL basic_period: got %0d exp 100", w); end
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL basic_res0: got %0d exp 25", ifa.dat); end
    n_cmp++; if (ifa.dat_all !== {16'd0, 16'd25}) begin n_err++; $display("FAIL basic_dat_all: got %0h exp 00000019", ifa.dat_all); end
    n_cmp++; if (ifa.ovf !== 2'b00) begin n_err++; $display("FAIL basic_ovf: got %0b exp 00", ifa.ovf); end
    n_cmp++; if (ifb.dat !== 4'(EXP_B)) begin n_err++; $display("FAIL narrow_res0: got %0d exp %0d", ifb.dat, EXP_B); end
    n_cmp++; if (ifb.ovf !== 2'b01) begin n_err++; $display("FAIL narrow_ovf: got %0b exp 01", ifb.ovf); end
    n_cmp++; if (ifb.ovf_sel !== 1'b1) begin n_err++; $display("FAIL narrow_ovf_sel: got %0b exp 1", ifb.ovf_sel); end
    n_cmp++; if (ifa.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b exp 1", ifa.busy); end
    @(posedge clk); #1;
    n_cmp++; if (ifa.vld !== 1'b0) begin n_err++; $display("FAIL vld_pulse_width: got %0b exp 0", ifa.vld); end
    wait_vld(ok, w);
    n_cmp++; if (w !== 99) begin n_err++; $display("FAIL basic_period2: got %0d exp 99", w); end
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL basic_res0_2: got %0d exp 25", ifa.dat); end
  endtask

  task automatic test_gate_zero;
    bit ok; int w, a, b;
    ifa.gate_ms = '0;
    wait_vld(ok, w);
    wait_vld(ok, w);
    wait_vld(ok, w);
    a = int'(ifa.dat);
    n_cmp++; if (w !== 10) begin n_err++; $display("FAIL g0_period: got %0d exp 10", w); end
    n_cmp++; if (a < 2 || a > 3) begin n_err++; $display("FAIL g0_res_a: got %0d exp 2..3", a); end
    wait_vld(ok, w);
    b = int'(ifa.dat);
    n_cmp++; if (b < 2 || b > 3) begin n_err++; $display("FAIL g0_res_b: got %0d exp 2..3", b); end
    n_cmp++; if (a + b !== 5) begin n_err++; $display("FAIL g0_sum: got %0d exp 5", a + b); end
    ifa.gate_ms = 10'd10;
    wait_vld(ok, w);
    wait_vld(ok, w);
    n_cmp++; if (w !== 100) begin n_err++; $display("FAIL g10_restore_period: got %0d exp 100", w); end
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL g10_restore_res0: got %0d exp 25", ifa.dat); end
  endtask

  task automatic test_hold;
    bit ok; int w, seen;
    ifa.hold = 1'b1;
    per0 = 2;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ifa.vld) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL hold_vld: got %0d pulses exp 0", seen); end
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL hold_res0: got %0d exp 25", ifa.dat); end
    ifa.hold = 1'b0;
    wait_vld(ok, w);
    n_cmp++; if (w !== 100) begin n_err++; $display("FAIL post_hold_period: got %0d exp 100", w); end
    n_cmp++; if (ifa.dat !== 16'd50) begin n_err++; $display("FAIL post_hold_res0: got %0d exp 50", ifa.dat); end
    per0 = 4;
    wait_vld(ok, w);
  endtask

  task automatic test_reset_mid;
    bit ok, found; int w;
    repeat (37) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ifa.dat_all !== 32'd0) begin n_err++; $display("FAIL mrst_dat_all: got %0h exp 0", ifa.dat_all); end
    n_cmp++; if (ifa.dat !== 16'd0) begin n_err++; $display("FAIL mrst_dat: got %0d exp 0", ifa.dat); end
    n_cmp++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %0b exp 0", ifa.busy); end
    n_cmp++; if (ifb.ovf !== 2'b00) begin n_err++; $display("FAIL mrst_ovf_b: got %0b exp 00", ifb.ovf); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (ifa.busy) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL mrst_rearm: busy %0b exp 1 within 50 clk", ifa.busy); end
    n_cmp++; if (ifa.dat !== 16'd0) begin n_err++; $display("FAIL mrst_cleared: got %0d exp 0", ifa.dat); end
    wait_vld(ok, w);
    n_cmp++; if (w !== 100) begin n_err++; $display("FAIL mrst_first_vld: got %0d clk exp 100", w); end
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL mrst_res0: got %0d exp 25", ifa.dat); end
  endtask

  task automatic test_ch_sel;
    bit ok; int w;
    en1 = 1'b1;
    wait_vld(ok, w);
    wait_vld(ok, w);
    ifa.ch_sel = 2'd0; #1;
    n_cmp++; if (ifa.dat !== 16'd25) begin n_err++; $display("FAIL sel0_dat: got %0d exp 25", ifa.dat); end
    n_cmp++; if (ifa.ovf_sel !== 1'b0) begin n_err++; $display("FAIL sel0_ovf: got %0b exp 0", ifa.ovf_sel); end
    ifa.ch_sel = 2'd1; #1;
    n_cmp++; if (ifa.dat !== 16'd20) begin n_err++; $display("FAIL sel1_dat: got %0d exp 20", ifa.dat); end
    ifa.ch_sel = 2'd2; #1;
    n_cmp++; if (ifa.dat !== 16'd0) begin n_err++; $display("FAIL sel2_dat: got %0d exp 0", ifa.dat); end
    n_cmp++; if (ifa.ovf_sel !== 1'b0) begin n_err++; $display("FAIL sel2_ovf: got %0b exp 0", ifa.ovf_sel); end
    ifa.ch_sel = 2'd3; #1;
    n_cmp++; if (ifa.dat !== 16'd0) begin n_err++; $display("FAIL sel3_dat: got %0d exp 0", ifa.dat); end
    n_cmp++; if (ifa.dat_all !== {16'd20, 16'd25}) begin n_err++; $display("FAIL sel_dat_all: got %0h exp 00140019", ifa.dat_all); end
    ifa.ch_sel = 2'd0;
  endtask

  initial begin
    ifa.gate_ms = 10'd10;
    ifa.hold    = 1'b0;
    ifa.ch_sel  = 2'd0;
    test_reset();
    test_basic();
    test_gate_zero();
    test_hold();
    test_reset_mid();
    test_ch_sel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
